// File: rtl/stream_reduce.sv
// Frame-level bit reducer: folds every masked bit of a multi-beat valid/ready
// word stream into one AND/OR/parity result and reports the beat count.
module stream_reduce #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       Mode,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    input  logic [WIDTH-1:0] InMask,
    input  logic             InLast,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             OutResult,
    output logic [CNT_W-1:0] OutBeats
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XNOR = 2'b11;

    // Masked-off bits are replaced by the neutral element of the op.
    function automatic logic wordred(input logic [WIDTH-1:0] d,
                                     input logic [WIDTH-1:0] m,
                                     input logic [1:0]       md);
        case (md)
            MODE_AND: wordred = &(d | ~m);
            MODE_OR:  wordred = |(d & m);
            default:  wordred = ^(d & m);
        endcase
    endfunction

    function automatic logic combine(input logic a, input logic b, input logic [1:0] md);
        case (md)
            MODE_AND: combine = a & b;
            MODE_OR:  combine = a | b;
            default:  combine = a ^ b;
        endcase
    endfunction

    // XNOR accumulates as XOR; inversion happens only at result time.
    function automatic logic finish(input logic a, input logic [1:0] md);
        finish = (md == MODE_XNOR) ? ~a : a;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] b);
        sat_inc = (b == {CNT_W{1'b1}}) ? b : b + CNT_W'(1);
    endfunction

    state_t           state, state_n;
    logic             acc, acc_n;
    logic [1:0]       mode_q, mode_n;
    logic [CNT_W-1:0] beats, beats_n;
    logic             res, res_n;
    logic [CNT_W-1:0] obeats, obeats_n;

    logic             accept;
    logic [1:0]       beat_mode;
    logic             beat_red;

    assign InReady   = (state != HOLD);
    assign OutValid  = (state == HOLD);
    assign OutResult = res;
    assign OutBeats  = obeats;

    // The live Mode input only matters on the opening beat of a frame.
    assign accept    = InValid && InReady;
    assign beat_mode = (state == IDLE) ? Mode : mode_q;
    assign beat_red  = wordred(InData, InMask, beat_mode);

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        mode_n   = mode_q;
        beats_n  = beats;
        res_n    = res;
        obeats_n = obeats;
        case (state)
            IDLE: begin
                if (accept) begin
                    mode_n  = Mode;
                    acc_n   = beat_red;
                    beats_n = CNT_W'(1);
                    state_n = InLast ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_n   = combine(acc, beat_red, mode_q);
                    beats_n = sat_inc(beats);
                    if (InLast) state_n = HOLD;
                end
            end
            HOLD: begin
                if (OutReady) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (accept && InLast) begin
            res_n    = finish(acc_n, mode_n);
            obeats_n = beats_n;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            acc    <= 1'b0;
            mode_q <= MODE_AND;
            beats  <= '0;
            res    <= 1'b0;
            obeats <= '0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            mode_q <= mode_n;
            beats  <= beats_n;
            res    <= res_n;
            obeats <= obeats_n;
        end
    end

endmodule
